read_stream_buffer: RTL and testbench
=====================================

Name: read_stream_buffer

Overview:
- Upstream feeder for the systolic Pair-HMM array.
- Accepts haplotype (reference) and read (exp) bases plus read Phred qualities over a load handshake, and stores them in local buffers.
- Serves the array's indexed x/y fetch requests with registered base_reads / prior_reads responses. Priors are derived from the qualities through a ROM.
- Sequences each job: load, pulse array reset, serve fetches, wait for array complete, report done.

Parameters:
- NUM_PROCS, 4: PE count; also the number of exp bases and priors returned per y fetch.
- MAX_STRING_LENGTH, 64: buffer depth. The maximum usable length is MAX_STRING_LENGTH-1, because lengths are carried in IW = $clog2(MAX_STRING_LENGTH) bits.
- QUAL_FLOOR, 6: minimum quality applied when QUAL_FLOOR_EN is defined.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- load_valid  in  1  load beat valid
- load_ready  out  1  buffer accepts a beat
- load_target  in  1  0 = haplotype, 1 = read
- load_base  in  STRING  base code
- load_qual  in  6  Phred quality; ignored for haplotype beats
- load_last  in  1  final beat of the current target string
- read_index_x  in  IW  haplotype fetch index
- read_x_valid  in  1  haplotype fetch request
- read_index_y  in  IW  read fetch start index
- read_y_valid  in  1  read fetch request
- base_reads  out  READS  reference, exp[NUM_PROCS], valid
- prior_reads  out  PRIORS  match[NUM_PROCS], neq[NUM_PROCS], valid
- string_length  out  IW  job length driven to the array
- array_reset  out  1  one-cycle reset pulse to the array
- array_complete  in  1  array finished
- job_done  out  1  one-cycle pulse when a job completes
- error  out  1  sticky error flag; cleared only by reset

Behaviour:
Reset values:
- State LOAD; hap_len = 0, read_len = 0; hap_last_seen = 0, read_last_seen = 0.
- All outputs 0, except load_ready = 1.

Load handshake:
- A beat transfers when load_valid & load_ready.
- The beat writes buffer[target][len_target] and increments len_target.
- load_last sets that target's last_seen flag.
- A beat arriving for a target whose last_seen is already set is dropped and sets error.
- A beat that would increment a length past MAX_STRING_LENGTH-1 is dropped and sets error.
- load_ready = 1 only in LOAD.

FSM:
- LOAD -> START when both last_seen flags are set. If hap_len != read_len, go to ERROR instead.
- START: array_reset = 1 for exactly one cycle; string_length = hap_len, held stable through SERVE. Next state SERVE.
- SERVE: answer fetches. On array_complete: job_done = 1 for one cycle, clear lengths, flags and both response valids, go to LOAD.
- ERROR: load_ready = 0, fetches ignored. Only reset exits ERROR.

Fetch response:
- One-cycle registered latency. Fetch inputs are sampled only in SERVE.
- On read_x_valid: base_reads.reference <= hap[read_index_x].
- On read_y_valid: for each i, exp[i] <= read[y+i]; match[i]/neq[i] <= ROM(qual[y+i]).
- x and y fetches in the same cycle are both served. Fields not requested hold their previous value.
- Both valid bits rise on the first served fetch after START. They stay high, with data held, until job_done or reset, because the array consumes reference several cycles after the request.

Boundaries:
- x >= hap_len: reference = PAD.
- y+i >= read_len: exp[i] = PAD, match[i] = 0, neq[i] = 0.
- The index sum y+i is computed at IW+1 bits so it cannot wrap.

Prior ROM (IEEE-754 double):
- err = 10^(-q/10); match = 1-err; neq = err/3.
- q=0: match 0x0000000000000000, neq 0x3FD5555555555555.
- q=10: match 0x3FECCCCCCCCCCCCD, neq 0x3FA1111111111111.

Reset mid-job: returns to LOAD with all buffers logically empty; array_reset is not pulsed.

Optional Feature:
QUAL_FLOOR_EN
- Defined: qualities below QUAL_FLOOR are raised to QUAL_FLOOR at load time, before storage.
- Undefined: qualities are stored unmodified. The QUAL_FLOOR parameter is then unused.

Decomposition:
- Shared package: STRING, PAD code, READS, PRIORS, NUM_PROCS, MAX_STRING_LENGTH. The FSM enum also lives there, alongside ARRAY_STATE.
- Sub-module phred_prior_rom: 64-entry combinational ROM, quality in, {match, neq} out. Instantiated NUM_PROCS times, or shared behind a mux.

Test Plan:
- Load hap ACGT and read ACGA with quals 10,10,10,0 -> array_reset pulses one cycle; string_length = 4; load_ready = 0.
- Then y fetch at index 0 -> next cycle exp = ACGA; match[0] = 0x3FECCCCCCCCCCCCD; neq[3] = 0x3FD5555555555555; prior_reads.valid = 1.
- x fetch at index 3 -> reference = T one cycle later and held for 5 idle cycles. x fetch at index 7 -> PAD.
- y fetch at index 2 with length 4 -> exp[2] = PAD, exp[3] = PAD; match/neq for entries 2 and 3 = 0.
- Read stream closes at length 3 against hap length 4 -> ERROR, error = 1, array_reset never pulses, fetches ignored until reset.
- With QUAL_FLOOR_EN and a q=2 beat -> priors equal the q=6 ROM entry. Separately, array_complete in SERVE -> job_done pulse, load_ready = 1 next cycle, both valid bits = 0.

Source files
------------

// File: rtl/read_stream_buffer_pkg.sv
// Shared types and sizing for the Pair-HMM read stream buffer: base codes,
// fetch response structs and the sequencing state enum.
package read_stream_buffer_pkg;

    localparam int NUM_PROCS         = 4;
    localparam int MAX_STRING_LENGTH = 64;
    localparam int IW                = $clog2(MAX_STRING_LENGTH);
    localparam int IW1               = IW + 1;
    localparam int QW                = 6;
    localparam logic [QW-1:0] QUAL_FLOOR = 6'd6;

    typedef logic [2:0]  STRING;
    typedef logic [63:0] prob_t;

    localparam STRING BASE_A = 3'd0;
    localparam STRING BASE_C = 3'd1;
    localparam STRING BASE_G = 3'd2;
    localparam STRING BASE_T = 3'd3;
    localparam STRING BASE_N = 3'd4;
    localparam STRING PAD    = 3'd7;

    typedef struct packed {
        STRING                  reference;
        STRING [NUM_PROCS-1:0]  exp;
        logic                   valid;
    } READS;

    typedef struct packed {
        prob_t [NUM_PROCS-1:0]  match;
        prob_t [NUM_PROCS-1:0]  neq;
        logic                   valid;
    } PRIORS;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_SERVE = 2'd2,
        ST_ERROR = 2'd3
    } ARRAY_STATE;

endpackage

// File: rtl/read_stream_buffer_prior_rom.sv
// Phred quality to Pair-HMM prior ROM: match = 1 - 10^(-q/10), neq = 10^(-q/10) / 3,
// both as IEEE-754 doubles. Contents are fixed at elaboration.
module phred_prior_rom
    import read_stream_buffer_pkg::*;
(
    input  logic [QW-1:0] qual_i,
    output logic [63:0]   match_o,
    output logic [63:0]   neq_o
);

    prob_t match_tbl [64];
    prob_t neq_tbl   [64];

    for (genvar g = 0; g < 64; g++) begin : g_tbl
        localparam real ERR = 10.0 ** (-real'(g) / 10.0);
        assign match_tbl[g] = $realtobits(1.0 - ERR);
        assign neq_tbl[g]   = $realtobits(ERR / 3.0);
    end

    assign match_o = match_tbl[qual_i];
    assign neq_o   = neq_tbl[qual_i];

endmodule

// File: rtl/read_stream_buffer.sv
// Upstream feeder for the systolic Pair-HMM array: buffers haplotype/read strings,
// sequences each job and serves indexed fetches. Optional QUAL_FLOOR_EN floors qualities at load.
module read_stream_buffer
    import read_stream_buffer_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          load_target,
    input  STRING         load_base,
    input  logic [QW-1:0] load_qual,
    input  logic          load_last,
    input  logic [IW-1:0] read_index_x,
    input  logic          read_x_valid,
    input  logic [IW-1:0] read_index_y,
    input  logic          read_y_valid,
    output READS          base_reads,
    output PRIORS         prior_reads,
    output logic [IW-1:0] string_length,
    output logic          array_reset,
    input  logic          array_complete,
    output logic          job_done,
    output logic          error,
    output logic [1:0]    dbg_state_o
);

    ARRAY_STATE    state_q;
    logic [IW-1:0] hap_len_q, read_len_q;
    logic          hap_last_q, read_last_q;
    READS          base_q;
    PRIORS         prior_q;
    logic [IW-1:0] len_out_q;
    logic          array_reset_q, job_done_q, error_q;

    STRING         hap_mem  [MAX_STRING_LENGTH];
    STRING         read_mem [MAX_STRING_LENGTH];
    logic [QW-1:0] qual_mem [MAX_STRING_LENGTH];

    logic [QW-1:0] qual_d;
`ifdef QUAL_FLOOR_EN
    assign qual_d = (load_qual < QUAL_FLOOR) ? QUAL_FLOOR : load_qual;
`else
    assign qual_d = load_qual;
`endif

    // Load handshake: valid/ready, one beat per cycle while ready; a closed or full target drops the beat.
    logic          beat, beat_ok;
    logic [IW-1:0] tgt_len;
    logic          tgt_closed;
    assign load_ready = (state_q == ST_LOAD);
    assign beat       = load_valid && load_ready;
    assign tgt_len    = load_target ? read_len_q : hap_len_q;
    assign tgt_closed = load_target ? read_last_q : hap_last_q;
    assign beat_ok    = beat && !tgt_closed && (tgt_len != IW'(MAX_STRING_LENGTH - 1));

    logic [IW:0] y_idx     [NUM_PROCS];
    logic        y_in      [NUM_PROCS];
    prob_t       rom_match [NUM_PROCS];
    prob_t       rom_neq   [NUM_PROCS];

    for (genvar i = 0; i < NUM_PROCS; i++) begin : g_lane
        assign y_idx[i] = {1'b0, read_index_y} + IW1'(i);
        assign y_in[i]  = (y_idx[i] < {1'b0, read_len_q});
        phred_prior_rom u_rom (
            .qual_i  (qual_mem[y_idx[i][IW-1:0]]),
            .match_o (rom_match[i]),
            .neq_o   (rom_neq[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset && beat_ok) begin
            if (load_target) begin
                read_mem[read_len_q] <= load_base;
                qual_mem[read_len_q] <= qual_d;
            end else begin
                hap_mem[hap_len_q] <= load_base;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            hap_len_q     <= '0;
            read_len_q    <= '0;
            hap_last_q    <= 1'b0;
            read_last_q   <= 1'b0;
            base_q        <= '0;
            prior_q       <= '0;
            len_out_q     <= '0;
            array_reset_q <= 1'b0;
            job_done_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            array_reset_q <= 1'b0;
            job_done_q    <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (hap_last_q && read_last_q) begin
                        if (hap_len_q != read_len_q) begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q       <= ST_START;
                            array_reset_q <= 1'b1;
                            len_out_q     <= hap_len_q;
                        end
                    end
                    if (beat && !beat_ok) begin
                        error_q <= 1'b1;
                    end else if (beat_ok && load_target) begin
                        read_len_q <= read_len_q + IW'(1);
                        if (load_last) read_last_q <= 1'b1;
                    end else if (beat_ok) begin
                        hap_len_q <= hap_len_q + IW'(1);
                        if (load_last) hap_last_q <= 1'b1;
                    end
                end
                ST_START: state_q <= ST_SERVE;
                ST_SERVE: begin
                    if (array_complete) begin
                        state_q       <= ST_LOAD;
                        job_done_q    <= 1'b1;
                        hap_len_q     <= '0;
                        read_len_q    <= '0;
                        hap_last_q    <= 1'b0;
                        read_last_q   <= 1'b0;
                        len_out_q     <= '0;
                        base_q.valid  <= 1'b0;
                        prior_q.valid <= 1'b0;
                    end else begin
                        if (read_x_valid) begin
                            base_q.reference <= (read_index_x < hap_len_q) ? hap_mem[read_index_x] : PAD;
                        end
                        if (read_y_valid) begin
                            for (int i = 0; i < NUM_PROCS; i++) begin
                                base_q.exp[i]    <= y_in[i] ? read_mem[y_idx[i][IW-1:0]] : PAD;
                                prior_q.match[i] <= y_in[i] ? rom_match[i] : '0;
                                prior_q.neq[i]   <= y_in[i] ? rom_neq[i] : '0;
                            end
                        end
                        // Valids stay up once served: the array consumes data several cycles later.
                        if (read_x_valid || read_y_valid) begin
                            base_q.valid  <= 1'b1;
                            prior_q.valid <= 1'b1;
                        end
                    end
                end
                ST_ERROR: error_q <= 1'b1;
                default:  state_q <= ST_LOAD;
            endcase
        end
    end

    assign base_reads    = base_q;
    assign prior_reads   = prior_q;
    assign string_length = len_out_q;
    assign array_reset   = array_reset_q;
    assign job_done      = job_done_q;
    assign error         = error_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_read_stream_buffer.sv
// Bench for read_stream_buffer: queue-based job model compared every cycle,
// plus literal expectations for the directed job and boundary cases.
module tb_read_stream_buffer;
    import read_stream_buffer_pkg::*;

    localparam int PH_LOAD = 0, PH_START = 1, PH_SERVE = 2, PH_ERROR = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0, load_target = 1'b0, load_last = 1'b0;
    STRING         load_base = '0;
    logic [QW-1:0] load_qual = '0;
    logic [IW-1:0] read_index_x = '0, read_index_y = '0;
    logic          read_x_valid = 1'b0, read_y_valid = 1'b0, array_complete = 1'b0;
    logic          load_ready, array_reset, job_done, error;
    READS          base_reads;
    PRIORS         prior_reads;
    logic [IW-1:0] string_length;
    logic [1:0]    dbg_state;

    always #5 clock = ~clock;

    read_stream_buffer dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_target(load_target),
        .load_base(load_base), .load_qual(load_qual), .load_last(load_last),
        .read_index_x(read_index_x), .read_x_valid(read_x_valid),
        .read_index_y(read_index_y), .read_y_valid(read_y_valid),
        .base_reads(base_reads), .prior_reads(prior_reads),
        .string_length(string_length), .array_reset(array_reset),
        .array_complete(array_complete), .job_done(job_done), .error(error),
        .dbg_state_o(dbg_state)
    );

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [519:0] act, logic [519:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: strings as queues, job phase, and the outputs expected after the next edge.
    STRING         hq[$], rq[$];
    logic [QW-1:0] qq[$];
    bit            h_closed, r_closed, m_err;
    int            phase;
    READS          e_reads;
    PRIORS         e_priors;
    logic [IW-1:0] e_len;
    bit            e_areset, e_done;

    function automatic logic [63:0] m_match(int q);
        real e;
        e = 10.0 ** (-real'(q) / 10.0);
        return $realtobits(1.0 - e);
    endfunction

    function automatic logic [63:0] m_neq(int q);
        real e;
        e = 10.0 ** (-real'(q) / 10.0);
        return $realtobits(e / 3.0);
    endfunction

    function automatic int floor_q(int q);
`ifdef QUAL_FLOOR_EN
        return (q < 6) ? 6 : q;
`else
        return q;
`endif
    endfunction

    task automatic model_clear();
        hq.delete(); rq.delete(); qq.delete();
        h_closed = 0; r_closed = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
            m_err = 0; phase = PH_LOAD;
            e_reads = '0; e_priors = '0; e_len = '0; e_areset = 0; e_done = 0;
            return;
        end
        e_areset = 0; e_done = 0;
        if (phase == PH_LOAD) begin
            if (h_closed && r_closed) begin
                if (hq.size() != rq.size()) begin
                    phase = PH_ERROR; m_err = 1;
                end else begin
                    phase = PH_START; e_areset = 1; e_len = IW'(hq.size());
                end
            end
            if (load_valid) begin
                if (load_target ? r_closed : h_closed) m_err = 1;
                else if ((load_target ? rq.size() : hq.size()) >= MAX_STRING_LENGTH - 1) m_err = 1;
                else if (load_target) begin
                    rq.push_back(load_base);
                    qq.push_back(QW'(floor_q(int'(load_qual))));
                    if (load_last) r_closed = 1;
                end else begin
                    hq.push_back(load_base);
                    if (load_last) h_closed = 1;
                end
            end
        end else if (phase == PH_START) begin
            phase = PH_SERVE;
        end else if (phase == PH_SERVE) begin
            if (array_complete) begin
                model_clear();
                e_done = 1; e_len = '0; phase = PH_LOAD;
                e_reads.valid = 0; e_priors.valid = 0;
            end else begin
                if (read_x_valid)
                    e_reads.reference = (int'(read_index_x) < hq.size()) ? hq[read_index_x] : PAD;
                if (read_y_valid) begin
                    for (int i = 0; i < NUM_PROCS; i++) begin
                        int k;
                        k = int'(read_index_y) + i;
                        if (k < rq.size()) begin
                            e_reads.exp[i]    = rq[k];
                            e_priors.match[i] = m_match(int'(qq[k]));
                            e_priors.neq[i]   = m_neq(int'(qq[k]));
                        end else begin
                            e_reads.exp[i]    = PAD;
                            e_priors.match[i] = '0;
                            e_priors.neq[i]   = '0;
                        end
                    end
                end
                if (read_x_valid || read_y_valid) begin
                    e_reads.valid = 1; e_priors.valid = 1;
                end
            end
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            chk("base_reads",    520'(base_reads),    520'(e_reads));
            chk("prior_reads",   520'(prior_reads),   520'(e_priors));
            chk("load_ready",    520'(load_ready),    520'(phase == PH_LOAD));
            chk("string_length", 520'(string_length), 520'(e_len));
            chk("array_reset",   520'(array_reset),   520'(e_areset));
            chk("job_done",      520'(job_done),      520'(e_done));
            chk("error",         520'(error),         520'(m_err));
        end
    end

    task automatic step();
        model_step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(int n);
        load_valid = 0; load_last = 0; read_x_valid = 0; read_y_valid = 0; array_complete = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1; idle(2); reset = 0;
    endtask

    task automatic beat(bit tgt, STRING b, int q, bit last);
        load_valid = 1; load_target = tgt; load_base = b; load_qual = QW'(q); load_last = last;
        step();
        load_valid = 0; load_last = 0;
    endtask

    task automatic fetch(bit xv, int x, bit yv, int y);
        read_x_valid = xv; read_index_x = IW'(x);
        read_y_valid = yv; read_index_y = IW'(y);
        step();
        read_x_valid = 0; read_y_valid = 0;
    endtask

    // mode 0: normal job; 1: read one base short (ERROR, then reset); 2: reset during SERVE
    task automatic random_job(int len, int mode);
        STRING hs[$], rs[$];
        int    qs[$];
        int    hi, ri, rlen, ncyc;
        rlen = (mode == 1) ? len - 1 : len;
        for (int i = 0; i < len; i++) hs.push_back(STRING'($urandom_range(0, 4)));
        for (int i = 0; i < rlen; i++) begin
            rs.push_back(STRING'($urandom_range(0, 4)));
            qs.push_back($urandom_range(0, 63));
        end
        hi = 0; ri = 0;
        while (hi < len || ri < rlen) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else if (hi < len && (ri >= rlen || $urandom_range(0, 1) == 1)) begin
                beat(0, hs[hi], $urandom_range(0, 63), hi == len - 1); hi++;
            end else begin
                beat(1, rs[ri], qs[ri], ri == rlen - 1); ri++;
            end
        end
        idle(2);
        ncyc = $urandom_range(5, 30);
        for (int c = 0; c < ncyc; c++) begin
            int xi, yi;
            xi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, len + 2);
            yi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, len + 2);
            if (xi > 63) xi = 63;
            if (yi > 63) yi = 63;
            fetch($urandom_range(0, 1) == 1, xi, $urandom_range(0, 1) == 1, yi);
        end
        if (mode == 0) begin
            array_complete = 1; step(); array_complete = 0;
            idle($urandom_range(0, 2));
        end else begin
            do_reset();
        end
    endtask

    initial begin
        STRING want[4];
        reset = 1;
        step();
        chk_en = 1;
        step(); step();
        reset = 0;
        chk("rst_load_ready", 520'(load_ready), 520'(1));
        chk("rst_error", 520'(error), 520'(0));
        chk("rst_base_valid", 520'(base_reads.valid), 520'(0));

        // Directed job: hap ACGT, read ACGA with quals 10,10,10,0
        beat(0, BASE_A, 0, 0);  beat(1, BASE_A, 10, 0);
        beat(0, BASE_C, 0, 0);  beat(1, BASE_C, 10, 0);
        beat(0, BASE_G, 0, 0);  beat(1, BASE_G, 10, 0);
        beat(0, BASE_T, 0, 1);  beat(1, BASE_A, 0, 1);
        idle(1);
        chk("start_array_reset", 520'(array_reset), 520'(1));
        chk("start_length", 520'(string_length), 520'(4));
        chk("start_load_ready", 520'(load_ready), 520'(0));
        idle(1);
        chk("serve_array_reset_low", 520'(array_reset), 520'(0));

        fetch(0, 0, 1, 0);
        want[0] = BASE_A; want[1] = BASE_C; want[2] = BASE_G; want[3] = BASE_A;
        for (int i = 0; i < 4; i++) chk($sformatf("y0_exp%0d", i), 520'(base_reads.exp[i]), 520'(want[i]));
        chk("y0_match0", 520'(prior_reads.match[0]), 520'(64'h3FECCCCCCCCCCCCD));
        chk("y0_neq0", 520'(prior_reads.neq[0]), 520'(64'h3FA1111111111111));
`ifdef QUAL_FLOOR_EN
        chk("y0_neq3_floor", 520'(prior_reads.neq[3]), 520'(m_neq(6)));
`else
        chk("y0_neq3", 520'(prior_reads.neq[3]), 520'(64'h3FD5555555555555));
        chk("y0_match3", 520'(prior_reads.match[3]), 520'(0));
`endif
        chk("y0_prior_valid", 520'(prior_reads.valid), 520'(1));

        fetch(1, 3, 0, 0);
        chk("x3_ref", 520'(base_reads.reference), 520'(BASE_T));
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("x3_ref_held", 520'(base_reads.reference), 520'(BASE_T));
        end
        fetch(1, 7, 0, 0);
        chk("x7_pad", 520'(base_reads.reference), 520'(PAD));

        fetch(0, 0, 1, 2);
        want[0] = BASE_G; want[1] = BASE_A; want[2] = PAD; want[3] = PAD;
        for (int i = 0; i < 4; i++) chk($sformatf("y2_exp%0d", i), 520'(base_reads.exp[i]), 520'(want[i]));
        chk("y2_match2", 520'(prior_reads.match[2]), 520'(0));
        chk("y2_neq3", 520'(prior_reads.neq[3]), 520'(0));

        array_complete = 1; step(); array_complete = 0;
        chk("done_pulse", 520'(job_done), 520'(1));
        chk("done_load_ready", 520'(load_ready), 520'(1));
        chk("done_base_valid", 520'(base_reads.valid), 520'(0));
        chk("done_prior_valid", 520'(prior_reads.valid), 520'(0));
        idle(1);
        chk("done_low", 520'(job_done), 520'(0));

        // Length mismatch: hap 4, read 3
        for (int i = 0; i < 4; i++) beat(0, STRING'(i), 0, i == 3);
        for (int i = 0; i < 3; i++) beat(1, STRING'(i), 20, i == 2);
        idle(1);
        chk("mismatch_error", 520'(error), 520'(1));
        chk("mismatch_ready", 520'(load_ready), 520'(0));
        fetch(1, 0, 1, 0);
        chk("error_fetch_ignored", 520'(base_reads.valid), 520'(0));
        idle(3);
        do_reset();
        chk("reset_clears_error", 520'(error), 520'(0));

        // Overflow: 63 beats fit, the 64th is dropped
        for (int i = 0; i < 63; i++) beat(0, STRING'($urandom_range(0, 4)), 0, 0);
        chk("full_no_error", 520'(error), 520'(0));
        beat(0, BASE_A, 0, 0);
        chk("overflow_error", 520'(error), 520'(1));
        do_reset();

        // Beat after last on the same target
        beat(0, BASE_C, 0, 0); beat(0, BASE_G, 0, 1);
        chk("closed_no_error", 520'(error), 520'(0));
        beat(0, BASE_T, 0, 0);
        chk("closed_drop_error", 520'(error), 520'(1));
        do_reset();

`ifdef QUAL_FLOOR_EN
        beat(0, BASE_A, 0, 1); beat(1, BASE_C, 2, 1);
        idle(2);
        fetch(0, 0, 1, 0);
        chk("floor_q2_match", 520'(prior_reads.match[0]), 520'(m_match(6)));
        array_complete = 1; step(); array_complete = 0;
`endif

        random_job(63, 0);
        for (int j = 0; j < 24; j++) random_job($urandom_range(1, 12), (j % 6 == 5) ? 1 : ((j % 6 == 3) ? 2 : 0));
        random_job(1, 0);

        idle(2);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
